vec_pack: RTL and testbench
===========================

VEC_PACK -- requirements
Module: vec_pack

Interface
REQ-001 Parameter EXP_WIDTH, default 8: exponent width of one float element.
REQ-002 Parameter MANT_WIDTH, default 23: mantissa width of one float element; FW = 1 + EXP_WIDTH + MANT_WIDTH.
REQ-003 Parameter VEC_SIZE, default 4: number of lanes per output vector; legal range is 1 or more.
REQ-004 Port clk, input, 1: the single clock; all state SHALL update on its rising edge only.
REQ-005 Port rst_n, input, 1: reset, synchronous and active-low.
REQ-006 Port in_valid, input, 1: the upstream element pair is valid.
REQ-007 Port in_ready, output, 1: the block accepts the element pair this cycle.
REQ-008 Port in_lhs, input, FW: lhs float element.
REQ-009 Port in_rhs, input, FW: rhs float element.
REQ-010 Port out_valid, output, 1: the packed vector pair is valid.
REQ-011 Port out_ready, input, 1: the downstream dot-product stage consumes the vector pair.
REQ-012 Port out_lhs, output, VEC_SIZE*FW: packed lhs vector; lane k occupies bits [k*FW +: FW].
REQ-013 Port out_rhs, output, VEC_SIZE*FW: packed rhs vector, with the same lane layout as out_lhs.
REQ-014 Port out_count, output, clog2(VEC_SIZE+1): number of lanes loaded from the input; the remaining lanes are padding.

Function
REQ-015 The block SHALL accept an element pair on a cycle when in_valid and in_ready are both high (a transfer).
REQ-016 The block SHALL deliver the vector pair on a cycle when out_valid and out_ready are both high (a drain).
REQ-017 The block SHALL have two states. FILL: out_valid=0. FULL: out_valid=1.
REQ-018 A write index idx, range 0..VEC_SIZE-1, SHALL select the destination lane; the n-th transfer after entering FILL SHALL be written to lane n-1 of both vectors.
REQ-019 In FILL, in_ready SHALL be 1; each transfer SHALL write the lane and increment idx.
REQ-020 In FILL, a transfer when idx = VEC_SIZE-1 SHALL move the block to FULL on the next cycle with out_count=VEC_SIZE and idx wrapping to 0.
REQ-021 In FULL, the stored vectors and out_count SHALL stay stable until a drain.
REQ-022 In FULL, in_ready SHALL equal out_ready (single-cycle pass-through).
REQ-023 A drain with no simultaneous transfer SHALL return the block to FILL with idx=0.
REQ-024 A drain with a simultaneous transfer SHALL write that element to lane 0, set idx=1 and return the block to FILL; when VEC_SIZE=1 the block SHALL instead stay in FULL.
REQ-025 On entry to FILL, lanes not yet written SHALL read as zero.
REQ-026 Output latency: out_valid SHALL rise on the cycle after the transfer that completes the vector.
REQ-027 No combinational path SHALL exist from in_valid to in_ready, or from in_valid to out_valid.
REQ-028 Element bits SHALL pass through unmodified; the block performs no float arithmetic.

Reset
REQ-029 When rst_n=0 at a clock edge, the block SHALL enter FILL with idx=0, out_valid=0, out_lhs=0, out_rhs=0 and out_count=0.
REQ-030 While in reset, in_ready SHALL be 0.
REQ-031 A reset asserted mid-fill or while FULL SHALL discard all loaded lanes with no partial output.

Configuration
REQ-032 The macro VEC_PACK_ZERO_PAD_EN SHALL control the zero-pad feature.
- Defined: the input port in_last (1 bit) SHALL exist.
- A transfer with in_last=1 in FILL SHALL write its lane, move the block to FULL with out_count = idx+1 and zero in the unwritten lanes, and reset idx to 0.
- When in_last=1 coincides with idx = VEC_SIZE-1, behaviour SHALL match REQ-020.
- Undefined: in_last SHALL be absent, and every vector SHALL contain exactly VEC_SIZE loaded lanes.

Verification
REQ-033 Set VEC_SIZE=4 and stream lhs 1.0,2.0,3.0,4.0 (0x3F800000, 0x40000000, 0x40400000, 0x40800000) and rhs 1.0 x4 with out_ready=1 -> out_valid high for one cycle after the 4th transfer, lane0 of out_lhs = 0x3F800000, lane3 = 0x40800000, out_count=4.
REQ-034 Complete a vector, then hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 and outputs stable throughout; raise out_ready -> drain, and the waiting element loads into lane 0 with idx=1.
REQ-035 Run back-to-back vectors with in_valid=1 and out_ready=1 continuously -> one vector every 4 cycles with no lost or duplicated element (scoreboard over 100 vectors).
REQ-036 Assert rst_n=0 after 2 transfers -> out_valid=0 and out_count=0; the next 4 transfers form a fresh vector with no residue from before reset.
REQ-037 With VEC_PACK_ZERO_PAD_EN defined, send 2 transfers with in_last on the 2nd -> out_count=2, lanes 2-3 = 0, out_valid rises on the next cycle.
REQ-038 Set VEC_SIZE=1 with in_valid=1 and out_ready=1 -> out_valid stays high every cycle and each cycle's output equals the previous cycle's input.

Source files
------------

// File: rtl/vec_pack_if.sv
// rtl/vec_pack_if.sv - element-pair input stream and packed-vector output stream of vec_pack
// in_last exists only when VEC_PACK_ZERO_PAD_EN is defined.
interface vec_pack_if #(
    parameter int EXP_WIDTH  = 8,
    parameter int MANT_WIDTH = 23,
    parameter int VEC_SIZE   = 4
);
    localparam int FW    = 1 + EXP_WIDTH + MANT_WIDTH;
    localparam int CNT_W = $clog2(VEC_SIZE + 1);

    logic                   in_valid;
    logic                   in_ready;
    logic [FW-1:0]          in_lhs;
    logic [FW-1:0]          in_rhs;
`ifdef VEC_PACK_ZERO_PAD_EN
    logic                   in_last;
`endif
    logic                   out_valid;
    logic                   out_ready;
    logic [VEC_SIZE*FW-1:0] out_lhs;
    logic [VEC_SIZE*FW-1:0] out_rhs;
    logic [CNT_W-1:0]       out_count;

    modport master (
`ifdef VEC_PACK_ZERO_PAD_EN
        output in_last,
`endif
        output in_valid, in_lhs, in_rhs, out_ready,
        input  in_ready, out_valid, out_lhs, out_rhs, out_count
    );

    modport slave (
`ifdef VEC_PACK_ZERO_PAD_EN
        input  in_last,
`endif
        input  in_valid, in_lhs, in_rhs, out_ready,
        output in_ready, out_valid, out_lhs, out_rhs, out_count
    );
endinterface

// File: rtl/vec_pack.sv
// rtl/vec_pack.sv - packs float element pairs into VEC_SIZE-lane lhs/rhs vectors
// Optional feature macro: VEC_PACK_ZERO_PAD_EN (in_last closes a short, zero-padded vector).
module vec_pack #(
    parameter int EXP_WIDTH  = 8,
    parameter int MANT_WIDTH = 23,
    parameter int VEC_SIZE   = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    vec_pack_if.slave bus
);
    localparam int FW    = 1 + EXP_WIDTH + MANT_WIDTH;
    localparam int IDX_W = (VEC_SIZE > 1) ? $clog2(VEC_SIZE) : 1;
    localparam int CNT_W = $clog2(VEC_SIZE + 1);

    typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [VEC_SIZE*FW-1:0] lhs_q, lhs_d;
    logic [VEC_SIZE*FW-1:0] rhs_q, rhs_d;
    logic [IDX_W-1:0]       idx_base;
    logic                   in_ready;
    logic                   transfer;
    logic                   drain;
    logic                   last;

`ifdef VEC_PACK_ZERO_PAD_EN
    assign last = bus.in_last;
`else
    assign last = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        count_d  = count_q;
        lhs_d    = lhs_q;
        rhs_d    = rhs_q;
        idx_base = idx_q;
        in_ready = rst_n && ((state_q == FILL) || bus.out_ready);
        transfer = bus.in_valid && in_ready;
        drain    = (state_q == FULL) && bus.out_ready;

        // A drain empties the vector first so a simultaneous transfer lands in lane 0.
        if (drain) begin
            state_d  = FILL;
            idx_d    = '0;
            idx_base = '0;
            count_d  = '0;
            lhs_d    = '0;
            rhs_d    = '0;
        end

        if (transfer) begin
            for (int k = 0; k < VEC_SIZE; k++) begin
                if (IDX_W'(k) == idx_base) begin
                    lhs_d[k*FW +: FW] = bus.in_lhs;
                    rhs_d[k*FW +: FW] = bus.in_rhs;
                end
            end
            if (last || (idx_base == IDX_W'(VEC_SIZE - 1))) begin
                state_d = FULL;
                count_d = CNT_W'(idx_base) + CNT_W'(1);
                idx_d   = '0;
            end else begin
                idx_d = idx_base + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FILL;
            idx_q   <= '0;
            count_q <= '0;
            lhs_q   <= '0;
            rhs_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            lhs_q   <= lhs_d;
            rhs_q   <= rhs_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == FULL);
    assign bus.out_lhs   = lhs_q;
    assign bus.out_rhs   = rhs_q;
    assign bus.out_count = count_q;
endmodule

// File: tb/tb_vec_pack.sv
// tb/tb_vec_pack.sv - self-checking bench for vec_pack (VEC_SIZE=4 and VEC_SIZE=1 instances)
module tb_vec_pack;
    localparam int FW = 32;
    localparam int VS = 4;
    localparam int LW = VS * FW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vec_pack_if #(.VEC_SIZE(VS)) bus ();
    vec_pack_if #(.VEC_SIZE(1))  bus1 ();

    vec_pack #(.EXP_WIDTH(8), .MANT_WIDTH(23), .VEC_SIZE(VS)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    vec_pack #(.EXP_WIDTH(8), .MANT_WIDTH(23), .VEC_SIZE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    int checks = 0;
    int failures = 0;
    int drains = 0;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: queue of accepted elements; every full (or closed) group becomes one expected vector.
    typedef struct {
        logic [LW-1:0] l;
        logic [LW-1:0] r;
        int            n;
    } vec_t;
    logic [FW-1:0] pend_l[$];
    logic [FW-1:0] pend_r[$];
    vec_t          exp_q[$];

    always @(negedge clk) begin : model
        vec_t v;
        logic lst;
        if (!rst_n) begin
            pend_l.delete();
            pend_r.delete();
            exp_q.delete();
        end else begin
            check("model_out_valid", bus.out_valid, exp_q.size() > 0);
            check("model_in_ready", bus.in_ready, (exp_q.size() == 0) || bus.out_ready);
            if (bus.out_valid && bus.out_ready && exp_q.size() > 0) begin
                v = exp_q.pop_front();
                check("sb_lhs", bus.out_lhs, v.l);
                check("sb_rhs", bus.out_rhs, v.r);
                check("sb_count", bus.out_count, v.n);
                drains++;
            end
            if (bus.in_valid && bus.in_ready) begin
                pend_l.push_back(bus.in_lhs);
                pend_r.push_back(bus.in_rhs);
                lst = 1'b0;
`ifdef VEC_PACK_ZERO_PAD_EN
                lst = bus.in_last;
`endif
                if (pend_l.size() == VS || lst) begin
                    v.l = '0;
                    v.r = '0;
                    v.n = pend_l.size();
                    for (int i = 0; i < pend_l.size(); i++) begin
                        v.l[i*FW +: FW] = pend_l[i];
                        v.r[i*FW +: FW] = pend_r[i];
                    end
                    exp_q.push_back(v);
                    pend_l.delete();
                    pend_r.delete();
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic orr, input logic [FW-1:0] l, input logic [FW-1:0] r);
        bus.in_valid  = iv;
        bus.out_ready = orr;
        bus.in_lhs    = l;
        bus.in_rhs    = r;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 32'hDEAD_BEEF, 32'hCAFE_F00D);
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1'b0);
        tick();
        drive(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_count", bus.out_count, 0);
        check("rst_out_lhs", bus.out_lhs, '0);
        check("rst_out_rhs", bus.out_rhs, '0);
        tick();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic          iv;
        logic          orr;
        logic [FW-1:0] l;
        logic [FW-1:0] r;
        logic          e_rdy;
        logic          e_vld;
        logic [2:0]    e_cnt;
    } row_t;

    row_t          tbl[6];
    logic [LW-1:0] exp_vec;
    logic [LW-1:0] exp_rhs;
    logic [FW-1:0] d;
    logic [FW-1:0] prev1;
    int            nd;
    int            bad_timing;
    int            vs1_bad;
    int            drains_start;

    initial begin
        tbl[0] = '{1'b1, 1'b1, 32'h3F80_0000, 32'h3F80_0000, 1'b1, 1'b0, 3'd0};
        tbl[1] = '{1'b1, 1'b1, 32'h4000_0000, 32'h3F80_0000, 1'b1, 1'b0, 3'd0};
        tbl[2] = '{1'b1, 1'b1, 32'h4040_0000, 32'h3F80_0000, 1'b1, 1'b0, 3'd0};
        tbl[3] = '{1'b1, 1'b1, 32'h4080_0000, 32'h3F80_0000, 1'b1, 1'b0, 3'd0};
        tbl[4] = '{1'b0, 1'b1, 32'h0,         32'h0,         1'b1, 1'b1, 3'd4};
        tbl[5] = '{1'b0, 1'b1, 32'h0,         32'h0,         1'b1, 1'b0, 3'd0};

        drive(1'b0, 1'b0, '0, '0);
        bus1.in_valid  = 1'b0;
        bus1.out_ready = 1'b0;
        bus1.in_lhs    = '0;
        bus1.in_rhs    = '0;
`ifdef VEC_PACK_ZERO_PAD_EN
        bus.in_last  = 1'b0;
        bus1.in_last = 1'b0;
`endif
        tick();
        do_reset();

        // Four float lanes with out_ready held high.
        for (int i = 0; i < 6; i++) begin
            drive(tbl[i].iv, tbl[i].orr, tbl[i].l, tbl[i].r);
            @(negedge clk);
            check($sformatf("tbl%0d_in_ready", i), bus.in_ready, tbl[i].e_rdy);
            check($sformatf("tbl%0d_out_valid", i), bus.out_valid, tbl[i].e_vld);
            check($sformatf("tbl%0d_out_count", i), bus.out_count, tbl[i].e_cnt);
            if (i == 4) begin
                exp_vec = {32'h4080_0000, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000};
                check("tbl_out_lhs", bus.out_lhs, exp_vec);
                check("tbl_out_rhs", bus.out_rhs, {4{32'h3F80_0000}});
            end
            tick();
        end

        // Backpressure while FULL, then drain with a waiting element.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 32'h1000_0000 + k, 32'h2000_0000 + k);
            @(negedge clk);
            tick();
        end
        exp_vec = {32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000};
        exp_rhs = {32'h2000_0003, 32'h2000_0002, 32'h2000_0001, 32'h2000_0000};
        drive(1'b1, 1'b0, 32'h1000_0004, 32'h2000_0004);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("hold_in_ready", bus.in_ready, 1'b0);
            check("hold_out_valid", bus.out_valid, 1'b1);
            check("hold_out_lhs", bus.out_lhs, exp_vec);
            check("hold_out_rhs", bus.out_rhs, exp_rhs);
            check("hold_out_count", bus.out_count, 4);
            tick();
        end
        drive(1'b1, 1'b1, 32'h1000_0004, 32'h2000_0004);
        @(negedge clk);
        check("release_in_ready", bus.in_ready, 1'b1);
        tick();
        drive(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("after_drain_valid", bus.out_valid, 1'b0);
        check("after_drain_lhs", bus.out_lhs, {96'h0, 32'h1000_0004});
        check("after_drain_count", bus.out_count, 0);
        tick();
        for (int k = 5; k < 8; k++) begin
            drive(1'b1, 1'b0, 32'h1000_0000 + k, 32'h2000_0000 + k);
            @(negedge clk);
            tick();
        end
        drive(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("idx1_out_valid", bus.out_valid, 1'b1);
        check("idx1_out_lhs", bus.out_lhs,
              {32'h1000_0007, 32'h1000_0006, 32'h1000_0005, 32'h1000_0004});
        tick();

        // Reset after two transfers discards them.
        do_reset();
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 1'b1, 32'hAAAA_0000 + k, 32'hBBBB_0000 + k);
            @(negedge clk);
            tick();
        end
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 32'h5000_0000 + k, 32'h6000_0000 + k);
            @(negedge clk);
            tick();
        end
        drive(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("fresh_out_lhs", bus.out_lhs,
              {32'h5000_0003, 32'h5000_0002, 32'h5000_0001, 32'h5000_0000});
        check("fresh_out_count", bus.out_count, 4);
        tick();

`ifdef VEC_PACK_ZERO_PAD_EN
        // Short vector closed by in_last.
        do_reset();
        drive(1'b1, 1'b1, 32'h7000_0000, 32'h7100_0000);
        @(negedge clk);
        tick();
        drive(1'b1, 1'b1, 32'h7000_0001, 32'h7100_0001);
        bus.in_last = 1'b1;
        @(negedge clk);
        check("zp_not_yet_valid", bus.out_valid, 1'b0);
        tick();
        bus.in_last = 1'b0;
        drive(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("zp_out_valid", bus.out_valid, 1'b1);
        check("zp_out_count", bus.out_count, 2);
        check("zp_out_lhs", bus.out_lhs, {64'h0, 32'h7000_0001, 32'h7000_0000});
        tick();
        drive(1'b0, 1'b1, '0, '0);
        @(negedge clk);
        tick();
`endif

        // Continuous streaming on both instances.
        do_reset();
        drains_start = drains;
        nd = 0;
        bad_timing = 0;
        vs1_bad = 0;
        prev1 = '0;
        for (int i = 0; i <= 400; i++) begin
            d = $urandom;
            drive(1'b1, 1'b1, $urandom, $urandom);
            bus1.in_valid  = 1'b1;
            bus1.out_ready = 1'b1;
            bus1.in_lhs    = d;
            bus1.in_rhs    = ~d;
            @(negedge clk);
            if (bus.out_valid) nd++;
            if (bus.out_valid !== ((i > 0) && (i % 4 == 0))) bad_timing++;
            if (i > 0) begin
                if (bus1.out_valid !== 1'b1 || bus1.out_lhs !== prev1 ||
                    bus1.out_rhs !== ~prev1 || bus1.out_count !== 1'b1) vs1_bad++;
            end
            prev1 = d;
            tick();
        end
        bus1.in_valid  = 1'b0;
        bus1.out_ready = 1'b0;
        check("bb_vector_count", nd, 100);
        check("bb_timing_errors", bad_timing, 0);
        check("bb_scoreboard_drains", drains - drains_start, 100);
        check("vs1_errors", vs1_bad, 0);

        // Random handshakes against the model.
        do_reset();
        drains_start = drains;
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, $urandom, $urandom);
            @(negedge clk);
            tick();
        end
        check("rand_drains_seen", (drains - drains_start) > 50, 1'b1);

        drive(1'b0, 1'b0, '0, '0);
        tick();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end
endmodule
